// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline-register definitions: default datapath widths, the bubble instruction
// and skid-buffer state encodings reused by every inter-stage register.
package riscv_pipe_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // 2'd3 is unreachable; the skid FSM treats it as EMPTY on the next edge.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid register with flush; out_dat is BUBBLE whenever empty.
// Latency 1 cycle; in_rdy is a flop, low only while both entries are held.
module pipe_skid_buf
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);

  skid_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_rdy_q;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_vld && in_rdy_q;
  assign out_fire = out_vld && out_rdy;
  assign out_vld  = (state_q == ST_ONE) || (state_q == ST_TWO);
  assign out_dat  = main_q;
  assign in_rdy   = in_rdy_q;

  // main_q is reloaded with BUBBLE on every path into EMPTY so out_dat needs no mux.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = BUBBLE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_dat;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_dat;
          end else if (in_fire) begin
            state_d = ST_TWO;
            skid_d  = in_dat;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      main_q   <= BUBBLE;
      skid_q   <= '0;
      in_rdy_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      in_rdy_q <= (state_d != ST_TWO);
    end
  end

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register: splits {inst,pc} around a 2-entry skid; NOP@0 when no entry held.
// Latency 1 cycle at full throughput; in_ready registered, drops only when the skid is full.
module if_id_skid_reg #(
  parameter int unsigned     XLEN     = riscv_pipe_pkg::XLEN,
  parameter int unsigned     ILEN     = riscv_pipe_pkg::ILEN,
  parameter logic [ILEN-1:0] NOP_INST = riscv_pipe_pkg::NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc
);

  localparam int unsigned W = ILEN + XLEN;
  localparam logic [W-1:0] BUBBLE = {NOP_INST, {XLEN{1'b0}}};

  logic [W-1:0] in_dat;
  logic [W-1:0] out_dat;

  assign in_dat            = {in_inst, in_pc};
  assign {out_inst, out_pc} = out_dat;

  pipe_skid_buf #(
    .WIDTH  (W),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (in_dat),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (out_dat)
  );

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: accepted inputs queue up, a negedge monitor checks
// order, occupancy-derived handshakes, hold stability and NOP bubbles.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int total = 0;
  int bad   = 0;

  logic [63:0] q[$];
  logic        prev_hold = 1'b0;
  logic [31:0] prev_inst = '0;
  logic [31:0] prev_pc = '0;

  always #5 clk = ~clk;

  if_id_skid_reg dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected-response side: record what the DUT accepted at the coming edge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({in_inst, in_pc});
    end
  end

  // Monitor: outputs are stable mid-cycle, ahead of the edge that consumes them.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_vld", 64'(out_valid), 64'd0);
      chk("rst_rdy", 64'(in_ready), 64'd1);
      chk("rst_inst", 64'(out_inst), 64'(NOP));
      chk("rst_pc", 64'(out_pc), 64'd0);
      prev_hold = 1'b0;
    end else begin
      chk("vld", 64'(out_valid), 64'(q.size() != 0));
      chk("rdy", 64'(in_ready), 64'(q.size() < 2));
      if (!out_valid) begin
        chk("bubble_inst", 64'(out_inst), 64'(NOP));
        chk("bubble_pc", 64'(out_pc), 64'd0);
      end
      if (prev_hold) begin
        chk("hold_inst", 64'(out_inst), 64'(prev_inst));
        chk("hold_pc", 64'(out_pc), 64'(prev_pc));
      end
      if (out_valid && out_ready && !flush && q.size() != 0)
        chk("data", {out_inst, out_pc}, q.pop_front());
      prev_hold = out_valid && !out_ready && !flush;
      prev_inst = out_inst;
      prev_pc   = out_pc;
    end
  end

  task automatic step(input logic v, input logic [31:0] i, input logic [31:0] p,
                      input logic r, input logic f);
    in_valid  = v;
    in_inst   = i;
    in_pc     = p;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pc;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset asserted mid-cycle while both entries are held.
    step(1'b1, 32'hAAAA_0001, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'hBBBB_0002, 32'h4, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    q.delete();
    #1;
    chk("t1_vld", 64'(out_valid), 64'd0);
    chk("t1_inst", 64'(out_inst), 64'h13);
    chk("t1_pc", 64'(out_pc), 64'd0);
    chk("t1_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming with no backpressure.
    step(1'b1, 32'hA000_000A, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'hB000_000B, 32'h4, 1'b1, 1'b0);
    step(1'b1, 32'hC000_000C, 32'h8, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Backpressure: C stalls at fetch until the skid drains.
    step(1'b1, 32'hA100_0001, 32'h100, 1'b0, 1'b0);
    step(1'b1, 32'hB100_0002, 32'h104, 1'b0, 1'b0);
    step(1'b1, 32'hC100_0003, 32'h108, 1'b0, 1'b0);
    step(1'b1, 32'hC100_0003, 32'h108, 1'b0, 1'b0);
    step(1'b1, 32'hC100_0003, 32'h108, 1'b1, 1'b0);
    step(1'b1, 32'hC100_0003, 32'h108, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush in TWO while D is offered.
    step(1'b1, 32'hA200_0001, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'hB200_0002, 32'h204, 1'b0, 1'b0);
    step(1'b1, 32'hD200_0004, 32'h208, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush coinciding with an output transfer in ONE.
    step(1'b1, 32'hE300_0005, 32'h300, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Random valid/ready/flush traffic.
    pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      step(1'($urandom_range(0, 1)), $urandom, pc,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0));
      pc = pc + 32'd4;
    end

    for (int n = 0; n < 4; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
